mem_access_sequencer: RTL and testbench
=======================================

# mem_access_sequencer

Multicycle sequencer for the load/store datapath. It accepts one memory operation at a time from the main control unit and steps the memory and MDR through each phase. It drives the 3-bit LoadStore control code and performs read-modify-write for halfword and byte stores. It also flags misaligned or illegal requests before any memory access occurs.

## Interface

Parameters:
- MEM_LATENCY, default 1: cycles from memory address valid to read data valid at the MDR input; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low; sampled on rising edge of clk.
- start  input  1  request strobe; accepted only when busy=0.
- op  input  3  operation: 001 lw, 010 lh, 011 lb, 100 sw, 101 sh, 110 sb; 000/111 illegal.
- addr  input  32  byte address of access.
- mem_addr  output  32  address to memory, word-aligned ({addr_q[31:2],2'b00}).
- mem_wr  output  1  memory write enable; 1 only in WRITE.
- mdr_load  output  1  MDR write enable; 1 only in LATCH.
- ls_control  output  3  LoadStore control code; op_q in EXEC, 000 otherwise.
- reg_wr  output  1  register-file write strobe for load result; 1 in DONE for loads only.
- busy  output  1  1 in every state except IDLE.
- done  output  1  one-cycle completion pulse (DONE or ERR).
- error  output  1  one-cycle pulse in ERR.

## Operation

- States: IDLE, READ, LATCH, EXEC, WRITE, DONE, ERR. The state register is binary-encoded. All outputs decode from the registered state and the captured registers (Moore).
- IDLE: when start=1, capture op into op_q and addr into addr_q.
  - Go to ERR if op is illegal, if op is lw/sw with addr[1:0]!=00, or if op is lh/sh with addr[0]!=0.
  - Otherwise go to READ for lw/lh/lb/sh/sb, or to EXEC for sw.
- READ: mem_addr is valid and mem_wr=0. A 4-bit counter loads MEM_LATENCY-1 on entry and decrements each cycle. Exit to LATCH on the cycle the count reads 0, so READ lasts exactly MEM_LATENCY cycles.
- LATCH: mdr_load=1 for one cycle, then EXEC.
- EXEC: ls_control=op_q for one cycle, so LoadStore registers its result at the end of EXEC.
  - Loads go to DONE.
  - Stores (sw/sh/sb) go to WRITE.
- WRITE: mem_wr=1 and mem_addr held, for one cycle; then DONE. The memory write data is the LoadStore output; for sh/sb it already contains the merged word.
- DONE: done=1. reg_wr=1 if op_q is a load. Next state is IDLE.
- ERR: done=1 and error=1. mem_wr, mdr_load and reg_wr stay 0. Next state is IDLE.
- mem_addr = {addr_q[31:2],2'b00} in all states, including IDLE, where it holds the last captured address.
- start while busy=1 is ignored; there is no queueing. op/addr changes while busy have no effect.
- The controller never issues a sub-word address; byte/halfword lane selection is outside this block.

## Timing

- Reset (reset=0 at an edge):
  - Next state is IDLE.
  - op_q=000, addr_q=0, counter=0.
  - All outputs are 0 on the following cycle, including mem_wr, mdr_load, ls_control, reg_wr, busy, done and error.
  - Reset overrides start in the same cycle.
  - Reset during WRITE deasserts mem_wr from the next cycle.
- Busy cycles from the accept edge to return to IDLE, with L=MEM_LATENCY:
  - lw/lh/lb: L+3.
  - sw: 3.
  - sh/sb: L+4.
  - error: 1.
- done is high in the last busy cycle. busy drops on the cycle after done.
- A new start is accepted in the first IDLE cycle, so back-to-back operations have no dead cycle beyond DONE.
- With L=1, READ lasts a single cycle. The counter never underflows.

## Test plan

- Reset, then lw at addr=0x0000_0010 with L=1: mem_addr=0x10 for 1 cycle, mdr_load in cycle 2, ls_control=001 in cycle 3, and done=reg_wr=1 in cycle 4; mem_wr stays 0 throughout.
- sb at addr=0x0000_0023 with L=3 and memory word 0xAABBCCDD: READ 3 cycles, then LATCH, EXEC ls_control=110, WRITE with mem_wr=1 and mem_addr=0x20, then done; busy for 7 cycles, and reg_wr never asserts.
- sw at addr 0x0000_0004: no READ, and mdr_load stays 0; EXEC ls_control=100, WRITE mem_wr=1, done in cycle 3.
- Misaligned and illegal requests: lw at 0x0000_0002, sh at 0x0000_0001, and op=111 each give done=error=1 after 1 cycle. mem_wr, mdr_load, reg_wr and ls_control all stay 0. Aligned lh at 0x0000_0002 proceeds normally.
- Start pulses during busy are ignored; a new start in the first IDLE cycle after done is accepted and completes normally.
- reset=0 asserted in WRITE of an sh: mem_wr=0 and busy=0 the next cycle, and no done pulse.

Source files
------------

// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_sequencer
// Brief    : Multicycle load/store sequencer. Steps memory read, MDR latch,
//            LoadStore execute and memory write phases for one request at a
//            time, with read-modify-write for sub-word stores and early
//            rejection of misaligned or illegal operations.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_sequencer #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic        mdr_load,
    output logic [2:0]  ls_control,
    output logic        reg_wr,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_EXEC  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [3:0] c_LAT_M1 = 4'(MEM_LATENCY - 1);
    localparam logic [2:0] c_OP_LW  = 3'b001;
    localparam logic [2:0] c_OP_LH  = 3'b010;
    localparam logic [2:0] c_OP_LB  = 3'b011;
    localparam logic [2:0] c_OP_SW  = 3'b100;
    localparam logic [2:0] c_OP_SH  = 3'b101;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [31:2] r_addr;
    logic [3:0]  r_cnt;
    logic        r_mem_wr;
    logic        r_mdr_load;
    logic [2:0]  r_ls;
    logic        r_reg_wr;
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    logic        w_accept;
    logic        w_req_bad;
    logic        w_op_load;
    logic [2:0]  w_ls_src;

    // Request qualification: illegal opcodes and word/halfword misalignment
    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_req_bad = (op == 3'b000) || (op == 3'b111)
                     || (((op == c_OP_LW) || (op == c_OP_SW)) && (addr[1:0] != 2'b00))
                     || (((op == c_OP_LH) || (op == c_OP_SH)) && addr[0]);
    assign w_op_load = (r_op == c_OP_LW) || (r_op == c_OP_LH) || (r_op == c_OP_LB);
    // sw goes straight from IDLE to EXEC, so op_q is not yet valid on that edge
    assign w_ls_src  = w_accept ? op : r_op;

    // Next-state selection for the access phases
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_req_bad)
                        w_next = S_ERR;
                    else if (op == c_OP_SW)
                        w_next = S_EXEC;
                    else
                        w_next = S_READ;
                end
            end
            S_READ:  if (r_cnt == 4'd0) w_next = S_LATCH;
            S_LATCH: w_next = S_EXEC;
            S_EXEC:  w_next = w_op_load ? S_DONE : S_WRITE;
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, captured request, latency counter and registered Moore outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_op       <= 3'b000;
            r_addr     <= '0;
            r_cnt      <= 4'd0;
            r_mem_wr   <= 1'b0;
            r_mdr_load <= 1'b0;
            r_ls       <= 3'b000;
            r_reg_wr   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op   <= op;
                r_addr <= addr[31:2];
            end
            if ((w_next == S_READ) && (r_state != S_READ))
                r_cnt <= c_LAT_M1;
            else if ((r_state == S_READ) && (r_cnt != 4'd0))
                r_cnt <= r_cnt - 4'd1;
            r_mem_wr   <= (w_next == S_WRITE);
            r_mdr_load <= (w_next == S_LATCH);
            r_ls       <= (w_next == S_EXEC) ? w_ls_src : 3'b000;
            r_reg_wr   <= (w_next == S_DONE) && w_op_load;
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE) || (w_next == S_ERR);
            r_error    <= (w_next == S_ERR);
        end
    end

    assign mem_addr   = {r_addr, 2'b00};
    assign mem_wr     = r_mem_wr;
    assign mdr_load   = r_mdr_load;
    assign ls_control = r_ls;
    assign reg_wr     = r_reg_wr;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_sequencer
// Brief    : Directed bench for mem_access_sequencer, one instance at
//            MEM_LATENCY=1 and one at MEM_LATENCY=3 sharing the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_sequencer;

    // Status word: {busy, done, error, mem_wr, mdr_load, reg_wr, ls_control}
    localparam logic [8:0] c_B = 9'h100;
    localparam logic [8:0] c_D = 9'h080;
    localparam logic [8:0] c_E = 9'h040;
    localparam logic [8:0] c_W = 9'h020;
    localparam logic [8:0] c_M = 9'h010;
    localparam logic [8:0] c_R = 9'h008;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;

    logic [31:0] mem_addr1, mem_addr3;
    logic        mem_wr1, mdr_load1, reg_wr1, busy1, done1, error1;
    logic        mem_wr3, mdr_load3, reg_wr3, busy3, done3, error3;
    logic [2:0]  ls1, ls3;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_access_sequencer #(.MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
        .mem_addr(mem_addr1), .mem_wr(mem_wr1), .mdr_load(mdr_load1),
        .ls_control(ls1), .reg_wr(reg_wr1), .busy(busy1), .done(done1),
        .error(error1)
    );

    mem_access_sequencer #(.MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr),
        .mem_addr(mem_addr3), .mem_wr(mem_wr3), .mdr_load(mdr_load3),
        .ls_control(ls3), .reg_wr(reg_wr3), .busy(busy3), .done(done3),
        .error(error3)
    );

    wire [8:0] w_st1 = {busy1, done1, error1, mem_wr1, mdr_load1, reg_wr1, ls1};
    wire [8:0] w_st3 = {busy3, done3, error3, mem_wr3, mdr_load3, reg_wr3, ls3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock and sample 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input string tag, input logic [8:0] exp);
        tick();
        check(tag, {23'd0, w_st1}, {23'd0, exp});
    endtask

    task automatic step3(input string tag, input logic [8:0] exp);
        tick();
        check(tag, {23'd0, w_st3}, {23'd0, exp});
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic req(input logic [2:0] o, input logic [31:0] a);
        start = 1'b1;
        op    = o;
        addr  = a;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        addr  = 32'h0;
        gap(2);
        check("rst_st1", {23'd0, w_st1}, 32'd0);
        check("rst_st3", {23'd0, w_st3}, 32'd0);
        check("rst_addr1", mem_addr1, 32'h0);
        reset = 1'b1;
        gap(1);

        // lw at 0x10, L=1
        req(3'b001, 32'h0000_0010);
        step1("lw_c1", c_B);
        start = 1'b0;
        check("lw_addr", mem_addr1, 32'h10);
        step1("lw_c2", c_B | c_M);
        step1("lw_c3", c_B | 9'd1);
        step1("lw_c4", c_B | c_D | c_R);
        step1("lw_c5", 9'd0);
        gap(6);

        // sb at 0x23, L=3
        req(3'b110, 32'h0000_0023);
        step3("sb_c1", c_B);
        start = 1'b0;
        check("sb_addr_rd", mem_addr3, 32'h20);
        step3("sb_c2", c_B);
        step3("sb_c3", c_B);
        step3("sb_c4", c_B | c_M);
        step3("sb_c5", c_B | 9'd6);
        step3("sb_c6", c_B | c_W);
        check("sb_addr_wr", mem_addr3, 32'h20);
        step3("sb_c7", c_B | c_D);
        step3("sb_c8", 9'd0);
        gap(4);

        // sw at 0x4: no read phase
        req(3'b100, 32'h0000_0004);
        step1("sw_c1", c_B | 9'd4);
        start = 1'b0;
        check("sw_addr", mem_addr1, 32'h4);
        step1("sw_c2", c_B | c_W);
        step1("sw_c3", c_B | c_D);
        step1("sw_c4", 9'd0);
        gap(4);

        // Rejected requests
        req(3'b001, 32'h0000_0002);
        step1("err_lw", c_B | c_D | c_E);
        start = 1'b0;
        step1("err_lw_idle", 9'd0);
        req(3'b101, 32'h0000_0001);
        step3("err_sh", c_B | c_D | c_E);
        start = 1'b0;
        step3("err_sh_idle", 9'd0);
        req(3'b111, 32'h0000_0000);
        step1("err_op7", c_B | c_D | c_E);
        start = 1'b0;
        step1("err_op7_idle", 9'd0);

        // Aligned lh at 0x2
        req(3'b010, 32'h0000_0002);
        step1("lh_c1", c_B);
        start = 1'b0;
        step1("lh_c2", c_B | c_M);
        step1("lh_c3", c_B | 9'd2);
        step1("lh_c4", c_B | c_D | c_R);
        step1("lh_c5", 9'd0);
        gap(6);

        // Start held during busy with changing op/addr, then back-to-back
        req(3'b011, 32'h0000_0007);
        step1("b2b_c1", c_B);
        op   = 3'b100;
        addr = 32'h0000_0100;
        check("b2b_addr1", mem_addr1, 32'h4);
        step1("b2b_c2", c_B | c_M);
        step1("b2b_c3", c_B | 9'd3);
        step1("b2b_c4", c_B | c_D | c_R);
        step1("b2b_c5", 9'd0);
        step1("b2b_c6", c_B | 9'd4);
        start = 1'b0;
        check("b2b_addr2", mem_addr1, 32'h100);
        step1("b2b_c7", c_B | c_W);
        step1("b2b_c8", c_B | c_D);
        step1("b2b_c9", 9'd0);
        gap(8);

        // Reset in WRITE of sh, L=3
        req(3'b101, 32'h0000_0002);
        step3("rstw_c1", c_B);
        start = 1'b0;
        step3("rstw_c2", c_B);
        step3("rstw_c3", c_B);
        step3("rstw_c4", c_B | c_M);
        step3("rstw_c5", c_B | 9'd5);
        step3("rstw_c6", c_B | c_W);
        reset = 1'b0;
        step3("rstw_c7", 9'd0);
        check("rstw_addr", mem_addr3, 32'h0);
        reset = 1'b1;
        step3("rstw_c8", 9'd0);

        // Reset wins over a simultaneous start
        reset = 1'b0;
        req(3'b001, 32'h0000_0010);
        step1("rst_start1", 9'd0);
        check("rst_start3", {23'd0, w_st3}, 32'd0);
        reset = 1'b1;
        start = 1'b0;
        gap(2);
        check("post_rst_idle", {23'd0, w_st1}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
